// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: drains a burst of words from a FIFO into a 2-entry buffer.
// Optional burst abort on a starved FIFO is compiled in with FIFO_RD_TIMEOUT_EN.
module fifo_rd_drain #(
  parameter int DATA_W  = 8,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  burst_len,
  input  logic              empty,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  word_count,
  output logic              timeout
);

  typedef enum logic [1:0] {
    IDLE, RUN, FLUSH, DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]   wc_q, wc_d;
  logic               infl_q;
  logic [1:0]         occ_q, occ_d;
  logic [1:0]         lvl;
  logic [DATA_W-1:0]  b0_q, b0_d;
  logic [DATA_W-1:0]  b1_q, b1_d;
  logic               push, pop, go;
  logic               abort;

  assign push    = infl_q;
  assign m_valid = (occ_q != 2'd0);
  assign pop     = m_valid && m_ready;
  assign go      = (state_q == IDLE) && start;
  assign m_data  = b0_q;
  assign word_count = wc_q;

  // a pop in this cycle frees a slot, so a full pipe keeps streaming
  assign lvl = occ_q - {1'b0, pop} + {1'b0, infl_q};

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wc_q    <= '0;
      infl_q  <= 1'b0;
      occ_q   <= 2'd0;
      b0_q    <= '0;
      b1_q    <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wc_q    <= wc_d;
      infl_q  <= rd_en;
      occ_q   <= occ_d;
      b0_q    <= b0_d;
      b1_q    <= b1_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = burst_len;
          state_d = (burst_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (rd_en) rem_d = rem_q - 1'b1;
        if (rem_q == '0) state_d = FLUSH;
        if (abort) begin
          rem_d   = '0;
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        if (!infl_q && (occ_q == 2'd0 ||
            (occ_q == 2'd1 && pop)))
          state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN) || (state_q == FLUSH);
    done  = (state_q == DONE);
    rd_en = (state_q == RUN) && !empty &&
            (rem_q != '0) && (lvl < 2'd2);
  end

  always_comb begin
    b0_d  = b0_q;
    b1_d  = b1_q;
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10: begin
        if (occ_q == 2'd0) b0_d = rd_data;
        else               b1_d = rd_data;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        b0_d  = b1_q;
        occ_d = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          b0_d = rd_data;
        end else begin
          b0_d = b1_q;
          b1_d = rd_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wc_d = wc_q;
    if (go)       wc_d = '0;
    else if (pop) wc_d = wc_q + 1'b1;
  end

`ifdef FIFO_RD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] ecnt_q, ecnt_d;
  logic          tmo_q, tmo_d;
  logic          stall;

  always_comb begin
    stall  = (state_q == RUN) && empty && (rem_q != '0);
    abort  = stall && (ecnt_q == TW'(TIMEOUT - 1));
    ecnt_d = stall ? ecnt_q + 1'b1 : '0;
    tmo_d  = go ? 1'b0 : (tmo_q | abort);
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      ecnt_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      ecnt_q <= ecnt_d;
      tmo_q  <= tmo_d;
    end
  end

  assign timeout = tmo_q;
`else
  assign abort   = 1'b0;
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_drain.sv
// tb_fifo_rd_drain: table-driven bursts plus reset and starvation sequences.
// Inputs change on the falling edge; outputs are sampled 1 ns later.
module tb_fifo_rd_drain;

  localparam int DW = 8;
  localparam int CW = 8;

  typedef struct {
    int len;
    int emode;
    int rmode;
    int base;
    int exp_wc;
    int exp_run;
    int exp_lo;
  } vec_t;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] burst_len = '0;
  logic          empty = 1'b0;
  logic          rd_en;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [CW-1:0] word_count;
  logic          timeout;

  fifo_rd_drain #(
    .DATA_W(DW), .CNT_W(CW), .TIMEOUT(8)
  ) dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst),
    .start(start), .burst_len(burst_len),
    .empty(empty), .rd_en(rd_en),
    .rd_data(rd_data), .m_data(m_data),
    .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .done(done),
    .word_count(word_count), .timeout(timeout)
  );

  always #5 rd_clk = ~rd_clk;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] src;
  logic          s_rd_en, s_valid, s_done;
  logic          s_busy, s_tmo;
  logic [DW-1:0] s_data;
  logic [CW-1:0] s_wc;

  vec_t vecs[8];

  task automatic chk(input string nm,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // one clock: drive at negedge, sample, model FIFO read
  task automatic cyc(input logic rst, input logic st,
                     input logic [CW-1:0] bl,
                     input logic emp, input logic rdy);
    rd_rst = rst; start = st; burst_len = bl;
    empty = emp; m_ready = rdy;
    #1;
    s_rd_en = rd_en; s_valid = m_valid;
    s_data = m_data; s_done = done;
    s_busy = busy; s_wc = word_count;
    s_tmo = timeout;
    @(posedge rd_clk);
    #1;
    if (s_rd_en) begin
      rd_data = src;
      src = src + 1'b1;
    end
    @(negedge rd_clk);
  endtask

  function automatic logic emp_f(int m, int c);
    case (m)
      1: return c[0];
      2: return c < 6;
      3: return c < 100;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic rdy_f(int m, int c);
    case (m)
      1: return c >= 10;
      2: return c[0];
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    logic [DW-1:0] got[$];
    int done_c, last_pop, run, maxrun;
    int lo, viol, unst, exp_gap;
    logic emp, rdy, st, stall_p;
    logic [CW-1:0] bl;
    logic [DW-1:0] data_p;
    done_c = -1; last_pop = -1; run = 0;
    maxrun = 0; lo = 0; viol = 0; unst = 0;
    stall_p = 1'b0; data_p = '0;
    src = v.base[DW-1:0];
    cyc(1'b0, 1'b1, v.len[CW-1:0], 1'b0, 1'b1);
    chk({nm, " busy@start"}, int'(s_busy), 0);
    for (int c = 1; c <= 2000 && done_c < 0; c++) begin
      emp = emp_f(v.emode, c);
      rdy = rdy_f(v.rmode, c);
      st = (c == 2);
      bl = st ? 8'd9 : 8'd0;
      cyc(1'b0, st, bl, emp, rdy);
      if (c == 1)
        chk({nm, " busy@1"}, int'(s_busy),
            int'(v.len != 0));
      if (s_rd_en && emp) viol++;
      if (s_rd_en) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
      if (v.rmode == 1 && c < 10 && s_rd_en) lo++;
      if (stall_p && (!s_valid || s_data != data_p))
        unst++;
      stall_p = s_valid && !rdy;
      data_p = s_data;
      if (s_valid && rdy) begin
        got.push_back(s_data);
        last_pop = c;
      end
      if (s_done) done_c = c;
    end
    chk({nm, " done seen"}, int'(done_c >= 0), 1);
    chk({nm, " words"}, got.size(), v.exp_wc);
    for (int k = 0; k < v.exp_wc; k++)
      chk({nm, " data"},
          k < got.size() ? int'(got[k]) : -1,
          (v.base + k) % 256);
    chk({nm, " word_count"}, int'(s_wc), v.exp_wc);
    exp_gap = (v.len == 0) ? 1 : last_pop + 1;
    chk({nm, " done cycle"}, done_c, exp_gap);
    chk({nm, " rd_en@empty"}, viol, 0);
    chk({nm, " m_data stable"}, unst, 0);
    if (v.exp_run >= 0)
      chk({nm, " rd_en run"}, maxrun, v.exp_run);
    if (v.exp_lo >= 0)
      chk({nm, " rd_en stalled"}, lo, v.exp_lo);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk({nm, " done width"}, int'(s_done), 0);
    chk({nm, " busy after"}, int'(s_busy), 0);
    chk({nm, " wc hold"}, int'(s_wc), v.exp_wc);
    chk({nm, " timeout"}, int'(s_tmo), 0);
  endtask

  initial begin
    int pops, mv, tmo_c, done_c, viol;
    logic emp;
    vec_t lw;
    vecs[0] = '{4, 0, 0, 8'h10, 4, 4, -1};
    vecs[1] = '{3, 0, 1, 8'h20, 3, -1, 2};
    vecs[2] = '{5, 1, 0, 8'h30, 5, -1, -1};
    vecs[3] = '{1, 0, 0, 8'h40, 1, 1, -1};
    vecs[4] = '{0, 0, 0, 8'h00, 0, 0, -1};
    vecs[5] = '{7, 0, 2, 8'h50, 7, -1, -1};
    vecs[6] = '{6, 2, 0, 8'hFC, 6, 6, -1};
    vecs[7] = '{255, 0, 0, 8'h00, 255, 255, -1};
    src = '0;
    @(negedge rd_clk);
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 1'b0, '0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("rst rd_en", int'(s_rd_en), 0);
    chk("rst m_valid", int'(s_valid), 0);
    chk("rst m_data", int'(s_data), 0);
    chk("rst busy", int'(s_busy), 0);
    chk("rst done", int'(s_done), 0);
    chk("rst word_count", int'(s_wc), 0);
    chk("rst timeout", int'(s_tmo), 0);

    for (int i = 0; i < 8; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset in the middle of a burst
    src = 8'hA0;
    pops = 0;
    cyc(1'b0, 1'b1, 8'd6, 1'b0, 1'b1);
    for (int c = 0; c < 20 && pops < 2; c++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      if (s_valid) pops++;
    end
    chk("mid pops", pops, 2);
    cyc(1'b1, 1'b0, '0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
    chk("mid rd_en", int'(s_rd_en), 0);
    chk("mid m_valid", int'(s_valid), 0);
    chk("mid m_data", int'(s_data), 0);
    chk("mid busy", int'(s_busy), 0);
    chk("mid done", int'(s_done), 0);
    chk("mid word_count", int'(s_wc), 0);
    chk("mid timeout", int'(s_tmo), 0);
    mv = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, 1'b0, '0, 1'b0, 1'b1);
      mv += int'(s_valid) + int'(s_rd_en);
    end
    chk("mid quiet", mv, 0);
    run_vec('{2, 0, 0, 8'h77, 2, 2, -1}, "post");

`ifdef FIFO_RD_TIMEOUT_EN
    // one word, then a starved FIFO until the abort
    src = 8'h55;
    pops = 0; tmo_c = -1; done_c = -1; viol = 0;
    cyc(1'b0, 1'b1, 8'd4, 1'b0, 1'b1);
    for (int c = 1; c <= 40 && done_c < 0; c++) begin
      emp = (c >= 2);
      cyc(1'b0, 1'b0, '0, emp, 1'b1);
      if (s_rd_en && emp) viol++;
      if (s_valid) pops++;
      if (s_tmo && tmo_c < 0) tmo_c = c;
      if (s_done) done_c = c;
    end
    chk("tmo rise", tmo_c, 10);
    chk("tmo done", done_c, 11);
    chk("tmo pops", pops, 1);
    chk("tmo word_count", int'(s_wc), 1);
    chk("tmo rd_en@empty", viol, 0);
    cyc(1'b0, 1'b0, '0, 1'b1, 1'b1);
    chk("tmo sticky", int'(s_tmo), 1);
    run_vec('{3, 0, 0, 8'h90, 3, 3, -1}, "tmo_clr");
`else
    // a starved FIFO is waited on indefinitely
    lw = '{2, 3, 0, 8'hC0, 2, 2, -1};
    run_vec(lw, "longwait");
`endif

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
